// File: rtl/rmii_package.sv
// rmii_package: shared types and constants for the RMII receive path
// Exports the receive FSM state type, the preamble/SFD dibit codes and the
// reflected CRC-32 constants used by the framer and by the CRC byte stage.
package rmii_package;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rmii_receive_state_t;
  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;
  localparam logic [31:0] CRC32_POLYNOMIAL = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC32_INITIAL = 32'hFFFF_FFFF;
endpackage

// File: rtl/ethernet_crc32_byte.sv
// ethernet_crc32_byte: one-byte step of the reflected Ethernet CRC-32
// Ports: crc (running remainder), data (byte, LSB first), next_crc (updated remainder).
module ethernet_crc32_byte
  import rmii_package::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] next_crc
);
  always_comb begin
    next_crc = crc;
    for (int i = 0; i < 8; i++)
      next_crc = (next_crc[0] ^ data[i]) ? (next_crc >> 1) ^ CRC32_POLYNOMIAL : next_crc >> 1;
  end
endmodule

// File: rtl/rmii_receive_framer.sv
// rmii_receive_framer: 100 Mb/s RMII receive front end, dibits to bytes plus per-frame status
// Ports: clock/reset; rmii_phy_receive_data/_enable/_error (RXD, CRS_DV, RX_ER);
// frame_data with valid/start/last pulses; frame_status_valid pulse with
// fcs/length/phy/alignment error flags and byte_count, all zero outside the pulse.
module rmii_receive_framer
  import rmii_package::*;
#(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int COUNT_WIDTH = $clog2(MAX_FRAME_BYTES + 2)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             rmii_phy_receive_data,
  input  logic                   rmii_phy_receive_data_enable,
  input  logic                   rmii_phy_receive_data_error,
  output logic [7:0]             frame_data,
  output logic                   frame_data_valid,
  output logic                   frame_data_start,
  output logic                   frame_data_last,
  output logic                   frame_status_valid,
  output logic                   frame_status_fcs_error,
  output logic                   frame_status_length_error,
  output logic                   frame_status_phy_error,
  output logic                   frame_status_alignment_error,
  output logic [COUNT_WIDTH-1:0] frame_status_byte_count
);
  localparam logic [COUNT_WIDTH-1:0] MIN_COUNT = COUNT_WIDTH'(MIN_FRAME_BYTES);
  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_FRAME_BYTES);
  rmii_receive_state_t state, state_next;
  logic [1:0] a_data, b_data, phase;
  logic a_enable, b_enable, a_error, b_error;
  logic [7:0] shift, hold, full_byte;
  logic hold_valid, hold_first, phy_seen;
  logic [31:0] crc, crc_next;
  logic [COUNT_WIDTH-1:0] count;
  logic live, in_data, sfd_seen, byte_done, frame_end, truncate, emit, status_fire, phy_now;
  // CRS_DV may toggle at frame end while data is still valid, so a dibit
  // whose own enable is low still counts when the next one is enabled.
  assign live = b_enable | a_enable;
  ethernet_crc32_byte u_crc (
    .crc(crc),
    .data(full_byte),
    .next_crc(crc_next)
  );
  always_ff @(posedge clock) state <= reset ? IDLE : state_next;
  // In IDLE only an enabled dibit starts a frame: a dibit that is live purely
  // through lookahead is still inter-frame gap, which keeps a 2-cycle gap legal.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     state_next = !b_enable ? IDLE : b_data == PREAMBLE_DIBIT ? PREAMBLE : DROP;
      PREAMBLE: state_next = !live ? IDLE : b_data == PREAMBLE_DIBIT ? PREAMBLE :
                             b_data == SFD_DIBIT ? DATA : DROP;
      DATA:     state_next = !live ? IDLE : truncate ? DROP : DATA;
      default:  state_next = !live ? IDLE : DROP;
    endcase
  end
  always_comb begin
    in_data = state == DATA;
    sfd_seen = state == PREAMBLE && live && b_data == SFD_DIBIT;
    full_byte = {b_data, shift[7:2]};
    byte_done = in_data && live && phase == 2'd3;
    frame_end = in_data && !live;
    truncate = byte_done && count == MAX_COUNT;
    emit = hold_valid && (byte_done || frame_end);
    status_fire = frame_end || truncate;
    phy_now = in_data && b_enable && b_error;
  end
  // The held byte is only released once the next byte completes or carrier
  // ends, so its last flag is always known when it is emitted.
  always_ff @(posedge clock) begin
    if (reset) begin
      {a_data, a_enable, a_error, b_data, b_enable, b_error} <= '0;
      phase <= '0;
      shift <= '0;
      hold <= '0;
      hold_valid <= 1'b0;
      hold_first <= 1'b0;
      phy_seen <= 1'b0;
      crc <= '0;
      count <= '0;
      frame_data <= '0;
      frame_data_valid <= 1'b0;
      frame_data_start <= 1'b0;
      frame_data_last <= 1'b0;
      frame_status_valid <= 1'b0;
      frame_status_fcs_error <= 1'b0;
      frame_status_length_error <= 1'b0;
      frame_status_phy_error <= 1'b0;
      frame_status_alignment_error <= 1'b0;
      frame_status_byte_count <= '0;
    end else begin
      {a_data, a_enable, a_error} <= {rmii_phy_receive_data, rmii_phy_receive_data_enable, rmii_phy_receive_data_error};
      {b_data, b_enable, b_error} <= {a_data, a_enable, a_error};
      if (sfd_seen) begin
        phase <= '0;
        crc <= CRC32_INITIAL;
        count <= '0;
        hold_valid <= 1'b0;
        phy_seen <= 1'b0;
      end
      if (in_data && live) begin
        phase <= phase + 2'd1;
        shift <= full_byte;
        phy_seen <= phy_seen | phy_now;
        if (byte_done) begin
          crc <= crc_next;
          count <= count + COUNT_WIDTH'(1);
          hold <= full_byte;
          hold_valid <= 1'b1;
          hold_first <= count == '0;
        end
      end
      if (emit) frame_data <= hold;
      frame_data_valid <= emit;
      frame_data_start <= emit && hold_first;
      frame_data_last <= emit && status_fire;
      frame_status_valid <= status_fire;
      frame_status_fcs_error <= status_fire && crc != CRC32_RESIDUE;
      frame_status_length_error <= truncate || (frame_end && count < MIN_COUNT);
      frame_status_phy_error <= status_fire && (phy_seen || phy_now);
      frame_status_alignment_error <= frame_end && phase != 2'd0;
      frame_status_byte_count <= status_fire ? count : '0;
    end
  end
endmodule

// File: tb/tb_rmii_receive_framer.sv
// tb_rmii_receive_framer: scoreboard bench for the RMII receive framer
module tb_rmii_receive_framer;
  typedef struct packed {logic [7:0] d; logic s; logic l;} exp_byte_t;
  typedef struct packed {logic [3:0] e; logic [10:0] c;} exp_stat_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] rxd = '0;
  logic rx_en = 1'b0;
  logic rx_er = 1'b0;
  logic [7:0] frame_data;
  logic frame_data_valid, frame_data_start, frame_data_last, frame_status_valid;
  logic fcs_e, len_e, phy_e, aln_e;
  logic [10:0] byte_count;
  exp_byte_t bq[$];
  exp_stat_t sq[$];
  exp_byte_t eb;
  exp_stat_t es;
  logic [7:0] frame[$];
  int checks = 0;
  int errors = 0;
  always #10 clock = ~clock;
  rmii_receive_framer dut (
    .clock(clock),
    .reset(reset),
    .rmii_phy_receive_data(rxd),
    .rmii_phy_receive_data_enable(rx_en),
    .rmii_phy_receive_data_error(rx_er),
    .frame_data(frame_data),
    .frame_data_valid(frame_data_valid),
    .frame_data_start(frame_data_start),
    .frame_data_last(frame_data_last),
    .frame_status_valid(frame_status_valid),
    .frame_status_fcs_error(fcs_e),
    .frame_status_length_error(len_e),
    .frame_status_phy_error(phy_e),
    .frame_status_alignment_error(aln_e),
    .frame_status_byte_count(byte_count)
  );
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? (c >> 1) ^ 32'hEDB8_8320 : c >> 1;
    return c;
  endfunction
  task automatic build(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    frame.delete();
    for (int i = 0; i < n - 4; i++) begin
      frame.push_back(8'(i * 7 + 3));
      c = crc_step(c, 8'(i * 7 + 3));
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frame.push_back(8'(c >> (8 * i)));
  endtask
  task automatic exp_bytes(input int n, input bit last);
    for (int i = 0; i < n; i++) bq.push_back('{frame[i], i == 0, last && i == n - 1});
  endtask
  task automatic exp_status(input logic [3:0] e, input int c);
    sq.push_back('{e, 11'(c)});
  endtask
  task automatic dibit(input logic [1:0] d, input logic e, input logic r);
    @(negedge clock);
    rxd = d;
    rx_en = e;
    rx_er = r;
  endtask
  task automatic idle(input int n);
    repeat (n) dibit(2'b00, 1'b0, 1'b0);
  endtask
  task automatic check_zero(input string name);
    checks++;
    if ({frame_data, frame_data_valid, frame_data_start, frame_data_last, frame_status_valid,
         fcs_e, len_e, phy_e, aln_e, byte_count} != '0) begin
      errors++;
      $display("FAIL %s: outputs data=%h v=%b s=%b l=%b sv=%b err=%b%b%b%b cnt=%0d, want all 0", name,
               frame_data, frame_data_valid, frame_data_start, frame_data_last, frame_status_valid,
               fcs_e, len_e, phy_e, aln_e, byte_count);
    end
  endtask
  // er_byte/rst_byte < 0 disable the error pulse / reset abort.
  task automatic send(input int extra, input bit tog, input int er_byte, input bit bad_pre,
                      input int rst_byte, input int gap);
    int total;
    logic [1:0] d;
    logic [7:0] t;
    total = frame.size() * 4 + extra;
    for (int i = 0; i < 32; i++) begin
      d = (i == 31) ? 2'b11 : 2'b01;
      if (bad_pre && i == 5) d = 2'b10;
      dibit(d, 1'b1, 1'b0);
    end
    for (int j = 0; j < total; j++) begin
      if (j / 4 == rst_byte && j % 4 == 0) begin
        @(negedge clock);
        reset = 1'b1;
        rx_en = 1'b0;
        rxd = 2'b00;
        rx_er = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check_zero("reset_abort");
        idle(gap);
        return;
      end
      t = (j / 4 < frame.size()) ? frame[j / 4] : 8'h00;
      d = t[2 * (j % 4) +: 2];
      dibit(d, (tog && j >= total - 8) ? ((total - 1 - j) % 2 == 0) : 1'b1, j / 4 == er_byte && j % 4 == 1);
    end
    idle(gap);
  endtask
  always @(negedge clock) begin
    if (!reset && frame_data_valid) begin
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL byte: unexpected byte %h s=%b l=%b", frame_data, frame_data_start, frame_data_last);
      end else begin
        eb = bq.pop_front();
        if ({frame_data, frame_data_start, frame_data_last} != eb) begin
          errors++;
          $display("FAIL byte: got %h s=%b l=%b want %h s=%b l=%b", frame_data, frame_data_start,
                   frame_data_last, eb.d, eb.s, eb.l);
        end
      end
    end
    if (!reset && frame_status_valid) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL status: unexpected status err=%b%b%b%b cnt=%0d", fcs_e, len_e, phy_e, aln_e, byte_count);
      end else begin
        es = sq.pop_front();
        if ({fcs_e, len_e, phy_e, aln_e, byte_count} != es) begin
          errors++;
          $display("FAIL status: got fcs/len/phy/aln=%b%b%b%b cnt=%0d want %b cnt=%0d",
                   fcs_e, len_e, phy_e, aln_e, byte_count, es.e, es.c);
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (4) @(negedge clock);
    check_zero("reset_state");
    reset = 1'b0;
    idle(4);
    build(64); exp_bytes(64, 1); exp_status(4'b0000, 64); send(0, 0, -1, 0, -1, 12);
    build(64); frame[20] = frame[20] ^ 8'h01; exp_bytes(64, 1); exp_status(4'b1000, 64); send(0, 0, -1, 0, -1, 12);
    build(40); exp_bytes(40, 1); exp_status(4'b0100, 40); send(0, 0, -1, 0, -1, 12);
    build(1600); exp_bytes(1522, 1); exp_status(4'b1100, 1522); send(0, 0, -1, 0, -1, 12);
    build(64); exp_bytes(64, 1); exp_status(4'b0010, 64); send(0, 0, 30, 0, -1, 12);
    build(64); exp_bytes(64, 1); exp_status(4'b0000, 64); send(0, 1, -1, 0, -1, 12);
    build(64); exp_bytes(64, 1); exp_status(4'b0001, 64); send(1, 0, -1, 0, -1, 12);
    build(64); exp_bytes(18, 0); send(0, 0, -1, 0, 20, 12);
    build(64); exp_bytes(64, 1); exp_status(4'b0000, 64); send(0, 0, -1, 0, -1, 12);
    build(64); exp_bytes(64, 1); exp_status(4'b0000, 64); send(0, 0, -1, 0, -1, 2);
    build(64); exp_bytes(64, 1); exp_status(4'b0000, 64); send(0, 0, -1, 0, -1, 12);
    build(64); send(0, 0, -1, 1, -1, 12);
    frame.delete(); exp_status(4'b1100, 0); send(0, 0, -1, 0, -1, 12);
    idle(20);
    checks++;
    if (bq.size() != 0) begin
      errors++;
      $display("FAIL byte_drain: %0d expected bytes never seen, want 0", bq.size());
    end
    checks++;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL status_drain: %0d expected status words never seen, want 0", sq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
